resource_ledger: RTL

RESOURCE_LEDGER -- requirements
Module: resource_ledger

---
 rtl/resource_ledger_pkg.sv | 53 +++++
 rtl/resource_ledger_web_cost_lut.sv | 29 ++
 rtl/resource_ledger.sv | 132 +++++++++++++
 3 files changed

// File: rtl/resource_ledger_pkg.sv
// Shared choice codes, cost table, FSM states and resource widths for the ledger.
// Latency: none (definitions only).
// Backpressure: not applicable.
package resource_ledger_pkg;

  localparam int CHOICE_W = 3;
  localparam int SHOT_W   = 3;
  localparam int ENERGY_W = 8;
  localparam int FLUID_W  = 4;
  localparam int TRACER_W = 6;

  localparam logic [CHOICE_W-1:0] CH_REFILL    = 3'd0;
  localparam logic [CHOICE_W-1:0] CH_SWINGLINE = 3'd1;
  localparam logic [CHOICE_W-1:0] CH_RICOCHET  = 3'd2;
  localparam logic [CHOICE_W-1:0] CH_GRENADE   = 3'd3;
  localparam logic [CHOICE_W-1:0] CH_TASER     = 3'd4;
  localparam logic [CHOICE_W-1:0] CH_RAPIDFIRE = 3'd5;
  localparam logic [CHOICE_W-1:0] CH_TRACER    = 3'd6;
  localparam logic [CHOICE_W-1:0] CH_ILLEGAL   = 3'd7;

  // Cost per shot: fluid / energy / tracers
  localparam logic [FLUID_W-1:0]  FC_SWINGLINE = 4'd1;
  localparam logic [ENERGY_W-1:0] EC_SWINGLINE = 8'd1;
  localparam logic [TRACER_W-1:0] TC_SWINGLINE = 6'd0;
  localparam logic [FLUID_W-1:0]  FC_RICOCHET  = 4'd1;
  localparam logic [ENERGY_W-1:0] EC_RICOCHET  = 8'd2;
  localparam logic [TRACER_W-1:0] TC_RICOCHET  = 6'd0;
  localparam logic [FLUID_W-1:0]  FC_GRENADE   = 4'd15;
  localparam logic [ENERGY_W-1:0] EC_GRENADE   = 8'd4;
  localparam logic [TRACER_W-1:0] TC_GRENADE   = 6'd0;
  localparam logic [FLUID_W-1:0]  FC_TASER     = 4'd1;
  localparam logic [ENERGY_W-1:0] EC_TASER     = 8'd16;
  localparam logic [TRACER_W-1:0] TC_TASER     = 6'd8;
  localparam logic [FLUID_W-1:0]  FC_RAPIDFIRE = 4'd1;
  localparam logic [ENERGY_W-1:0] EC_RAPIDFIRE = 8'd1;
  localparam logic [TRACER_W-1:0] TC_RAPIDFIRE = 6'd0;
  localparam logic [FLUID_W-1:0]  FC_TRACER    = 4'd1;
  localparam logic [ENERGY_W-1:0] EC_TRACER    = 8'd1;
  localparam logic [TRACER_W-1:0] TC_TRACER    = 6'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_BURST,
    ST_RESP
  } state_t;

  // Choices that resolve as a single shot in CHECK
  function automatic logic fires_in_check(input logic [CHOICE_W-1:0] ch);
    return (ch != CH_REFILL) && (ch != CH_RAPIDFIRE) && (ch != CH_ILLEGAL);
  endfunction

endpackage

// File: rtl/resource_ledger_web_cost_lut.sv
// Combinational choice -> per-shot fluid/energy/tracer cost lookup.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
module web_cost_lut
  import resource_ledger_pkg::*;
(
  input  logic [CHOICE_W-1:0] choice,
  output logic [FLUID_W-1:0]  fluid_cost,
  output logic [ENERGY_W-1:0] energy_cost,
  output logic [TRACER_W-1:0] tracer_cost
);

  // Refill and illegal choices cost nothing
  always_comb begin
    fluid_cost  = '0;
    energy_cost = '0;
    tracer_cost = '0;
    case (choice)
      CH_SWINGLINE: begin fluid_cost = FC_SWINGLINE; energy_cost = EC_SWINGLINE; tracer_cost = TC_SWINGLINE; end
      CH_RICOCHET:  begin fluid_cost = FC_RICOCHET;  energy_cost = EC_RICOCHET;  tracer_cost = TC_RICOCHET;  end
      CH_GRENADE:   begin fluid_cost = FC_GRENADE;   energy_cost = EC_GRENADE;   tracer_cost = TC_GRENADE;   end
      CH_TASER:     begin fluid_cost = FC_TASER;     energy_cost = EC_TASER;     tracer_cost = TC_TASER;     end
      CH_RAPIDFIRE: begin fluid_cost = FC_RAPIDFIRE; energy_cost = EC_RAPIDFIRE; tracer_cost = TC_RAPIDFIRE; end
      CH_TRACER:    begin fluid_cost = FC_TRACER;    energy_cost = EC_TRACER;    tracer_cost = TC_TRACER;    end
      default: ;
    endcase
  end

endmodule

// File: rtl/resource_ledger.sv
// Resource ledger: accepts a weapon choice, debits fluid/energy/tracers, pulses fire per shot.
// Latency: response 2 cycles after accept (single shot/refill), 1 cycle after last burst cycle for rapid fire.
// Backpressure: cmd_ready only in IDLE; one command in flight at a time.
module resource_ledger
  import resource_ledger_pkg::*;
#(
  parameter int ENERGY_INIT     = 255,
  parameter int FLUID_MAX       = 15,
  parameter int TRACER_INIT     = 63,
  parameter int RECHARGE_PERIOD = 16,
  parameter int RF_BURST        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CHOICE_W-1:0] cmd_choice,
  output logic                rsp_valid,
  output logic                rsp_ok,
  output logic [CHOICE_W-1:0] rsp_choice,
  output logic [SHOT_W-1:0]   rsp_shots,
  output logic                fire,
  output logic [ENERGY_W-1:0] energy,
  output logic [FLUID_W-1:0]  fluid,
  output logic [TRACER_W-1:0] tracers,
  output logic                busy
);

  localparam int RC_W = (RECHARGE_PERIOD > 1) ? $clog2(RECHARGE_PERIOD) : 1;
  localparam logic [ENERGY_W-1:0] E_INIT = ENERGY_W'(ENERGY_INIT);
  localparam logic [FLUID_W-1:0]  F_MAX  = FLUID_W'(FLUID_MAX);
  localparam logic [TRACER_W-1:0] T_INIT = TRACER_W'(TRACER_INIT);
  localparam logic [RC_W-1:0]     RC_TOP = RC_W'(RECHARGE_PERIOD - 1);
  localparam logic [SHOT_W-1:0]   LAST_SHOT = SHOT_W'(RF_BURST - 1);

  state_t              state, state_nxt;
  logic [CHOICE_W-1:0] choice_q;
  logic [SHOT_W-1:0]   shots_q;
  logic [RC_W-1:0]     rc_cnt;
  logic [FLUID_W-1:0]  fluid_cost;
  logic [ENERGY_W-1:0] energy_cost;
  logic [TRACER_W-1:0] tracer_cost;
  logic [ENERGY_W:0]   energy_sum;
  logic                tick, sufficient, shot, refill, accept;

  web_cost_lut u_cost (
    .choice      (choice_q),
    .fluid_cost  (fluid_cost),
    .energy_cost (energy_cost),
    .tracer_cost (tracer_cost)
  );

  // Checks use pre-recharge energy; the recharge is folded into the same update
  assign tick       = (rc_cnt == RC_TOP);
  assign sufficient = (fluid >= fluid_cost) && (energy >= energy_cost) && (tracers >= tracer_cost);
  assign cmd_ready  = (state == ST_IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state != ST_IDLE);

  // Response fields are only non-zero while the RESP state presents them
  assign rsp_valid  = (state == ST_RESP);
  assign rsp_choice = rsp_valid ? choice_q : '0;
  assign rsp_shots  = rsp_valid ? shots_q : '0;
  assign rsp_ok     = rsp_valid && ((choice_q == CH_REFILL) || (shots_q != '0));

  // Next state plus the per-cycle shot / refill decisions
  always_comb begin
    state_nxt = state;
    shot      = 1'b0;
    refill    = 1'b0;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (choice_q == CH_RAPIDFIRE) begin
          state_nxt = ST_BURST;
        end else begin
          state_nxt = ST_RESP;
          refill    = (choice_q == CH_REFILL);
          shot      = fires_in_check(choice_q) && sufficient;
        end
      end
      ST_BURST: begin
        shot = sufficient;
        if (!sufficient || (shots_q == LAST_SHOT)) state_nxt = ST_RESP;
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Energy after this cycle's deduction and recharge, before saturation
  always_comb begin
    energy_sum = {1'b0, energy} + {{ENERGY_W{1'b0}}, tick};
    if (shot) energy_sum = energy_sum - {1'b0, energy_cost};
  end

  // FSM state, latched choice and shot count for the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      choice_q <= '0;
      shots_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        choice_q <= cmd_choice;
        shots_q  <= '0;
      end else if (shot) begin
        shots_q <= shots_q + SHOT_W'(1);
      end
    end
  end

  // Resource registers, recharge counter and the fire pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      energy  <= E_INIT;
      fluid   <= F_MAX;
      tracers <= T_INIT;
      rc_cnt  <= '0;
      fire    <= 1'b0;
    end else begin
      rc_cnt <= tick ? '0 : rc_cnt + RC_W'(1);
      energy <= energy_sum[ENERGY_W] ? '1 : energy_sum[ENERGY_W-1:0];
      if (refill)    fluid <= F_MAX;
      else if (shot) fluid <= fluid - fluid_cost;
      if (shot) tracers <= tracers - tracer_cost;
      fire <= shot;
    end
  end

endmodule
